// File: rtl/alu_pc_unit.sv
// Execute-stage ALU plus next-PC calculator for the MIPS pipeline.
// Every result is registered and feeds the MEM stage and the fetch-PC mux.
module alu_pc_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       branch_mode,
   input  logic [WIDTH-1:0] last_pc,
   input  logic [1:0]       pc_inc,
   input  logic [WIDTH-1:0] abs_addr,
   input  logic [WIDTH-1:0] branch_addr,
   output logic [WIDTH-1:0] alu_result,
   output logic             alu_zero,
   output logic [WIDTH-1:0] next_pc,
   output logic [1:0]       pc_inc_q,
   output logic             branch_taken
);

   localparam int unsigned SHAMT_W = 5;
   localparam int unsigned HALF_W  = WIDTH / 2;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_NOR  = 4'd5,
      OP_SLT  = 4'd6,
      OP_SLTU = 4'd7,
      OP_SLL  = 4'd8,
      OP_SRL  = 4'd9,
      OP_SRA  = 4'd10,
      OP_LUI  = 4'd11
   } alu_op_e;

   typedef enum logic [1:0] {
      BR_NONE0 = 2'b00,
      BR_BEQ   = 2'b01,
      BR_BNE   = 2'b10,
      BR_NONE3 = 2'b11
   } br_mode_e;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'b00,
      PC_BRANCH = 2'b01,
      PC_JUMP   = 2'b10,
      PC_STOP   = 2'b11
   } pc_inc_e;

   logic [SHAMT_W-1:0] w_shamt;
   logic [WIDTH-1:0]   w_result;
   logic               w_zero;
   logic               w_cond;
   logic               w_taken;
   logic [WIDTH-1:0]   w_seq_pc;
   logic [WIDTH-1:0]   w_branch_pc;
   logic [WIDTH-1:0]   w_next_pc;

   logic [WIDTH-1:0]   r_alu_result;
   logic               r_alu_zero;
   logic [WIDTH-1:0]   r_next_pc;
   logic [1:0]         r_pc_inc;
   logic               r_branch_taken;

   assign w_shamt = b[SHAMT_W-1:0];

   // ALU datapath; unused encodings fall through to zero
   always_comb begin
      w_result = '0;
      unique case (alu_op_e'(alu_op))
         OP_ADD:  w_result = a + b;
         OP_SUB:  w_result = a - b;
         OP_AND:  w_result = a & b;
         OP_OR:   w_result = a | b;
         OP_XOR:  w_result = a ^ b;
         OP_NOR:  w_result = ~(a | b);
         OP_SLT:  w_result = WIDTH'(($signed(a) < $signed(b)) ? 1 : 0);
         OP_SLTU: w_result = WIDTH'((a < b) ? 1 : 0);
         OP_SLL:  w_result = a << w_shamt;
         OP_SRL:  w_result = a >> w_shamt;
         OP_SRA:  w_result = WIDTH'($signed(a) >>> w_shamt);
         OP_LUI:  w_result = {b[HALF_W-1:0], HALF_W'(0)};
         default: w_result = '0;
      endcase
   end

   assign w_zero = (w_result == '0);

   always_comb begin
      w_cond = 1'b0;
      unique case (br_mode_e'(branch_mode))
         BR_BEQ:  w_cond = w_zero;
         BR_BNE:  w_cond = ~w_zero;
         default: w_cond = 1'b0;
      endcase
   end

   assign w_seq_pc    = last_pc + WIDTH'(4);
   assign w_branch_pc = w_seq_pc + (branch_addr << 2);
   assign w_taken     = (pc_inc == PC_BRANCH) && w_cond;

   // Fetch-PC selection; a stop request parks the PC on the current instruction
   always_comb begin
      w_next_pc = w_seq_pc;
      unique case (pc_inc_e'(pc_inc))
         PC_SEQ:    w_next_pc = w_seq_pc;
         PC_BRANCH: w_next_pc = w_cond ? w_branch_pc : w_seq_pc;
         PC_JUMP:   w_next_pc = abs_addr;
         PC_STOP:   w_next_pc = last_pc;
         default:   w_next_pc = w_seq_pc;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_alu_result   <= '0;
         r_alu_zero     <= 1'b0;
         r_next_pc      <= '0;
         r_pc_inc       <= 2'b00;
         r_branch_taken <= 1'b0;
      end else if (en) begin
         r_alu_result   <= w_result;
         r_alu_zero     <= w_zero;
         r_next_pc      <= w_next_pc;
         r_pc_inc       <= pc_inc;
         r_branch_taken <= w_taken;
      end
   end

   assign alu_result   = r_alu_result;
   assign alu_zero     = r_alu_zero;
   assign next_pc      = r_next_pc;
   assign pc_inc_q     = r_pc_inc;
   assign branch_taken = r_branch_taken;

endmodule

// File: tb/tb_alu_pc_unit.sv
// Bench for alu_pc_unit: directed vector table, random vectors against a
// reference model, plus stall and asynchronous-reset sequences.
module tb_alu_pc_unit;

   logic        clk = 1'b0;
   logic        clr;
   logic        en;
   logic [3:0]  alu_op;
   logic [31:0] a, b;
   logic [1:0]  branch_mode;
   logic [31:0] last_pc;
   logic [1:0]  pc_inc;
   logic [31:0] abs_addr;
   logic [31:0] branch_addr;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic [31:0] next_pc;
   logic [1:0]  pc_inc_q;
   logic        branch_taken;

   alu_pc_unit #(.WIDTH(32)) dut (
      .clk(clk), .clr(clr), .en(en), .alu_op(alu_op), .a(a), .b(b),
      .branch_mode(branch_mode), .last_pc(last_pc), .pc_inc(pc_inc),
      .abs_addr(abs_addr), .branch_addr(branch_addr),
      .alu_result(alu_result), .alu_zero(alu_zero), .next_pc(next_pc),
      .pc_inc_q(pc_inc_q), .branch_taken(branch_taken)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  bm;
      logic [31:0] lpc;
      logic [1:0]  pinc;
      logic [31:0] abs_a;
      logic [31:0] br;
      logic [31:0] e_res;
      logic        e_zero;
      logic [31:0] e_pc;
      logic        e_taken;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic [31:0] pc;
      logic [1:0]  pinc;
      logic        taken;
   } exp_t;

   exp_t sb[$];
   exp_t last_exp;
   exp_t zero_exp;
   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic vec_t mk(logic [3:0] op, logic [31:0] va, logic [31:0] vb,
                               logic [1:0] bm, logic [31:0] lpc, logic [1:0] pinc,
                               logic [31:0] abs_a, logic [31:0] br,
                               logic [31:0] e_res, logic e_zero,
                               logic [31:0] e_pc, logic e_taken);
      vec_t v;
      v.op = op; v.a = va; v.b = vb; v.bm = bm; v.lpc = lpc; v.pinc = pinc;
      v.abs_a = abs_a; v.br = br; v.e_res = e_res; v.e_zero = e_zero;
      v.e_pc = e_pc; v.e_taken = e_taken;
      return v;
   endfunction

   // Reference model used for the random vectors
   function automatic vec_t model(vec_t v);
      vec_t        r = v;
      logic [31:0] res;
      logic [31:0] seq;
      logic        cond;
      int          sh;
      sh  = int'(v.b % 32);
      res = 32'h0;
      case (v.op)
         4'd0:  res = v.a + v.b;
         4'd1:  res = v.a + (~v.b + 32'd1);
         4'd2:  res = v.a & v.b;
         4'd3:  res = v.a | v.b;
         4'd4:  res = v.a ^ v.b;
         4'd5:  res = ~v.a & ~v.b;
         4'd6:  res = (v.a[31] != v.b[31]) ? {31'h0, v.a[31]} : {31'h0, (v.a < v.b)};
         4'd7:  res = {31'h0, (v.a < v.b)};
         4'd8:  for (int i = 0; i < 32; i++) res[i] = (i >= sh) ? v.a[i-sh] : 1'b0;
         4'd9:  for (int i = 0; i < 32; i++) res[i] = (i + sh < 32) ? v.a[i+sh] : 1'b0;
         4'd10: for (int i = 0; i < 32; i++) res[i] = (i + sh < 32) ? v.a[i+sh] : v.a[31];
         4'd11: res = v.b * 32'h10000;
         default: res = 32'h0;
      endcase
      r.e_res  = res;
      r.e_zero = (res == 32'h0);
      cond     = (v.bm == 2'b01) ? r.e_zero : ((v.bm == 2'b10) ? !r.e_zero : 1'b0);
      seq      = v.lpc + 32'd4;
      case (v.pinc)
         2'b00: r.e_pc = seq;
         2'b01: r.e_pc = cond ? seq + v.br * 32'd4 : seq;
         2'b10: r.e_pc = v.abs_a;
         default: r.e_pc = v.lpc;
      endcase
      r.e_taken = (v.pinc == 2'b01) && cond;
      return r;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp_v, $time);
      end
   endtask

   task automatic check_out(string tag, exp_t e);
      chk({tag, ".alu_result"}, alu_result, e.res);
      chk({tag, ".alu_zero"}, {31'h0, alu_zero}, {31'h0, e.zero});
      chk({tag, ".next_pc"}, next_pc, e.pc);
      chk({tag, ".pc_inc_q"}, {30'h0, pc_inc_q}, {30'h0, e.pinc});
      chk({tag, ".branch_taken"}, {31'h0, branch_taken}, {31'h0, e.taken});
   endtask

   task automatic set_inputs(vec_t v);
      alu_op = v.op; a = v.a; b = v.b; branch_mode = v.bm; last_pc = v.lpc;
      pc_inc = v.pinc; abs_addr = v.abs_a; branch_addr = v.br;
   endtask

   task automatic randomize_inputs();
      alu_op = 4'($urandom); a = $urandom; b = $urandom;
      branch_mode = 2'($urandom); last_pc = $urandom; pc_inc = 2'($urandom);
      abs_addr = $urandom; branch_addr = $urandom;
   endtask

   // Drive one vector, queue its expectation, compare after the capture edge
   task automatic apply(vec_t v, string tag);
      exp_t e;
      @(negedge clk);
      set_inputs(v);
      en = 1'b1;
      sb.push_back('{v.e_res, v.e_zero, v.e_pc, v.pinc, v.e_taken});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_out(tag, e);
      last_exp = e;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      zero_exp = '{32'h0, 1'b0, 32'h0, 2'b00, 1'b0};

      // Reset holds everything at zero regardless of inputs and clocks
      clr = 1'b0;
      en  = 1'b1;
      randomize_inputs();
      repeat (3) begin
         @(negedge clk);
         randomize_inputs();
      end
      #1;
      check_out("reset_hold", zero_exp);
      @(negedge clk);
      clr = 1'b1;

      // op, a, b, bmode, last_pc, pc_inc, abs, br_off, exp res, zero, next_pc, taken
      vecs.push_back(mk(4'd0,  32'd5,        32'd7,        2'b00, 32'h100, 2'b00, 0, 0, 32'd12,       0, 32'h104, 0));
      vecs.push_back(mk(4'd0,  32'hFFFFFFFF, 32'd1,        2'b00, 32'h100, 2'b00, 0, 0, 32'h0,        1, 32'h104, 0));
      vecs.push_back(mk(4'd1,  32'd3,        32'd5,        2'b00, 32'h100, 2'b00, 0, 0, 32'hFFFFFFFE, 0, 32'h104, 0));
      vecs.push_back(mk(4'd6,  32'hFFFFFFFF, 32'd1,        2'b00, 32'h100, 2'b00, 0, 0, 32'd1,        0, 32'h104, 0));
      vecs.push_back(mk(4'd7,  32'hFFFFFFFF, 32'd1,        2'b00, 32'h100, 2'b00, 0, 0, 32'd0,        1, 32'h104, 0));
      vecs.push_back(mk(4'd10, 32'h80000000, 32'h24,       2'b00, 32'h100, 2'b00, 0, 0, 32'hF8000000, 0, 32'h104, 0));
      vecs.push_back(mk(4'd9,  32'h80000000, 32'h24,       2'b00, 32'h100, 2'b00, 0, 0, 32'h08000000, 0, 32'h104, 0));
      vecs.push_back(mk(4'd8,  32'd1,        32'd31,       2'b00, 32'h100, 2'b00, 0, 0, 32'h80000000, 0, 32'h104, 0));
      vecs.push_back(mk(4'd11, 32'h0,        32'h1234ABCD, 2'b00, 32'h100, 2'b00, 0, 0, 32'hABCD0000, 0, 32'h104, 0));
      vecs.push_back(mk(4'd2,  32'hF0F0,     32'hFF00,     2'b00, 32'h100, 2'b00, 0, 0, 32'hF000,     0, 32'h104, 0));
      vecs.push_back(mk(4'd3,  32'hF0F0,     32'hFF00,     2'b00, 32'h100, 2'b00, 0, 0, 32'hFFF0,     0, 32'h104, 0));
      vecs.push_back(mk(4'd4,  32'hF0F0,     32'hFF00,     2'b00, 32'h100, 2'b00, 0, 0, 32'h0FF0,     0, 32'h104, 0));
      vecs.push_back(mk(4'd5,  32'h0,        32'h0,        2'b00, 32'h100, 2'b00, 0, 0, 32'hFFFFFFFF, 0, 32'h104, 0));
      vecs.push_back(mk(4'd13, 32'd5,        32'd5,        2'b00, 32'h100, 2'b00, 0, 0, 32'h0,        1, 32'h104, 0));
      // Branch cases: offset -2 words from 0x104
      vecs.push_back(mk(4'd1,  32'd9, 32'd9, 2'b01, 32'h100, 2'b01, 0, 32'hFFFFFFFE, 32'h0, 1, 32'h0FC, 1));
      vecs.push_back(mk(4'd1,  32'd9, 32'd9, 2'b10, 32'h100, 2'b01, 0, 32'hFFFFFFFE, 32'h0, 1, 32'h104, 0));
      vecs.push_back(mk(4'd1,  32'd9, 32'd4, 2'b10, 32'h100, 2'b01, 0, 32'hFFFFFFFE, 32'd5, 0, 32'h0FC, 1));
      vecs.push_back(mk(4'd1,  32'd9, 32'd9, 2'b01, 32'h100, 2'b00, 0, 32'hFFFFFFFE, 32'h0, 1, 32'h104, 0));
      vecs.push_back(mk(4'd1,  32'd9, 32'd9, 2'b11, 32'h100, 2'b01, 0, 32'hFFFFFFFE, 32'h0, 1, 32'h104, 0));
      vecs.push_back(mk(4'd1,  32'd9, 32'd9, 2'b01, 32'hFFFFFFF8, 2'b01, 0, 32'd1, 32'h0, 1, 32'h0, 1));
      vecs.push_back(mk(4'd1,  32'd9, 32'd9, 2'b01, 32'h100, 2'b01, 0, 32'h40000001, 32'h0, 1, 32'h108, 1));
      // Jump, stop, wrap
      vecs.push_back(mk(4'd1,  32'd9, 32'd9, 2'b01, 32'h100, 2'b10, 32'h00400020, 0, 32'h0, 1, 32'h00400020, 0));
      vecs.push_back(mk(4'd0,  32'd1, 32'd2, 2'b00, 32'h100, 2'b10, 32'h00400023, 0, 32'd3, 0, 32'h00400023, 0));
      vecs.push_back(mk(4'd0,  32'd1, 32'd2, 2'b00, 32'h200, 2'b11, 32'h00400020, 0, 32'd3, 0, 32'h200, 0));
      vecs.push_back(mk(4'd0,  32'd1, 32'd2, 2'b00, 32'hFFFFFFFC, 2'b00, 0, 0, 32'd3, 0, 32'h0, 0));

      foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 40; i++) begin
         vec_t v;
         v.op = 4'($urandom); v.a = $urandom; v.b = $urandom;
         if (i % 4 == 0) v.b = v.a;
         v.bm = 2'($urandom); v.lpc = $urandom; v.pinc = 2'($urandom);
         v.abs_a = $urandom; v.br = $urandom;
         apply(model(v), $sformatf("rnd%0d", i));
      end

      // Stall: outputs hold over three edges while inputs change
      apply(mk(4'd0, 32'd100, 32'd23, 2'b00, 32'h300, 2'b00, 0, 0, 32'd123, 0, 32'h304, 0), "pre_stall");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         en = 1'b0;
         randomize_inputs();
         @(posedge clk);
         #1;
         check_out($sformatf("stall%0d", i), last_exp);
      end

      // Asynchronous reset between edges clears outputs without a clock
      @(negedge clk);
      #2;
      clr = 1'b0;
      #1;
      check_out("async_clr", zero_exp);
      en = 1'b1;
      @(posedge clk);
      #1;
      check_out("clr_over_en", zero_exp);
      @(negedge clk);
      clr = 1'b1;
      apply(mk(4'd0, 32'd5, 32'd7, 2'b00, 32'h100, 2'b00, 0, 0, 32'd12, 0, 32'h104, 0), "post_clr");

      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover actual=%0d expected=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
